// File: rtl/frame_status_tx.sv
// frame_status_tx: once per video frame, snapshots a 32-bit status word on the falling edge
// of vsync and sends it to the host as a 5-byte UART 8N1 frame. The header byte is sent
// first, then the status word LSB byte first.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   n_vsync   active-low vsync, already in the i_clk domain
//   i_enable  1 = a vsync falling edge starts a frame, 0 = edges are ignored
//   status    status word, sampled only on the trigger cycle
//   o_tx      UART TX line, idles high, driven straight from a flop
//   o_busy    high while a frame is being shifted out
//   o_drop    one-cycle pulse when a trigger arrives while busy
module frame_status_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        n_vsync,
  input  logic        i_enable,
  input  logic [31:0] status,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int unsigned   CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            tx_q, tx_d;
  logic            drop_q, drop_d;
  logic            vsync_q;

  logic       trigger;
  logic       busy;
  logic       baud_last;
  logic [2:0] bit_nxt;
  logic [7:0] cur_byte;

  assign trigger   = ~n_vsync & vsync_q & i_enable;
  assign busy      = (state_q != StIdle);
  assign baud_last = (baud_q == BaudLast);
  assign bit_nxt   = bit_q + 3'd1;

  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = shadow_q[7:0];
      3'd2:    cur_byte = shadow_q[15:8];
      3'd3:    cur_byte = shadow_q[23:16];
      default: cur_byte = shadow_q[31:24];
    endcase
  end

  // tx_d always carries the line level of the bit that the next state starts, so o_tx
  // changes on exactly the cycle the FSM moves to the next bit.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    drop_d   = trigger & busy;

    case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        tx_d   = 1'b1;
        if (trigger) begin
          shadow_d = status;
          state_d  = StStart;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        baud_d = baud_last ? '0 : baud_q + CntW'(1);
        if (baud_last) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end
      end
      StData: begin
        baud_d = baud_last ? '0 : baud_q + CntW'(1);
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      StStop: begin
        baud_d = baud_last ? '0 : baud_q + CntW'(1);
        if (baud_last) begin
          if (byte_q < 3'd4) begin
            state_d = StStart;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            baud_d  = '0;
            bit_d   = '0;
            byte_d  = '0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      drop_q   <= 1'b0;
      vsync_q  <= 1'b1;  // no false edge right after reset
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      drop_q   <= drop_d;
      vsync_q  <= n_vsync;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy;
  assign o_drop = drop_q;

endmodule

// File: tb/tb_frame_status_tx.sv
module tb_frame_status_tx;

  logic        clk;
  logic        rst_n;
  logic        n_vsync, enable;
  logic [31:0] status;
  logic        tx, busy, drop;
  logic        n_vsync_b;
  logic [31:0] status_b;
  logic        tx_b, busy_b, drop_b;

  int errors = 0;
  int checks = 0;

  frame_status_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .n_vsync (n_vsync),
    .i_enable(enable),
    .status  (status),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_drop  (drop)
  );

  frame_status_tx #(.CLKS_PER_BIT(104), .HEADER(8'hA5)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .n_vsync (n_vsync_b),
    .i_enable(1'b1),
    .status  (status_b),
    .o_tx    (tx_b),
    .o_busy  (busy_b),
    .o_drop  (drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level of bit idx (0..49) of a frame carrying st: 10 bits per byte, start/data/stop.
  function automatic logic expected_bit(input logic [31:0] st, input int idx);
    int n = idx / 10;
    int p = idx % 10;
    logic [7:0] b;
    b = (n == 0) ? 8'hA5 : st[8*(n-1) +: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame with status st on this cycle and check all 200 cycles of it.
  // new_st is applied right after the trigger; drop_at injects a second edge at that
  // frame cycle; hold_low keeps vsync low; en_off_at clears i_enable mid-frame.
  task automatic frame(input logic [31:0] st, input logic [31:0] new_st, input int drop_at,
                       input bit hold_low, input int en_off_at);
    status  = st;
    n_vsync = 1'b0;
    tick();
    status = new_st;
    if (!hold_low) n_vsync = 1'b1;
    for (int i = 0; i < 200; i++) begin
      check("tx_bit", tx, expected_bit(st, i / 4));
      check("busy_frame", busy, 1);
      check("drop_frame", drop, (drop_at >= 0 && i == drop_at + 1));
      if (i == drop_at) n_vsync = 1'b0;
      else if (i == drop_at + 1 && !hold_low) n_vsync = 1'b1;
      if (i == en_off_at) enable = 1'b0;
      tick();
    end
    check("busy_end", busy, 0);
    check("tx_end", tx, 1);
    check("drop_end", drop, 0);
  endtask

  initial begin
    int busy_len, drop_cnt;
    logic [31:0] st;

    rst_n = 1'b0; n_vsync = 1'b1; enable = 1'b1; status = '0;
    n_vsync_b = 1'b1; status_b = '0;
    tick(); tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", busy, 0);
    end

    // Basic frame, then snapshot protection.
    frame(32'h1234_5678, 32'h1234_5678, -1, 1'b0, -1);
    tick();
    frame(32'h1234_5678, 32'hDEAD_BEEF, -1, 1'b0, -1);

    // Second edge 60 cycles into a frame is dropped; no follow-up frame.
    tick();
    frame(32'hCAFE_F00D, 32'h0, 59, 1'b0, -1);
    for (int i = 0; i < 30; i++) begin
      check("no_second_frame", busy, 0);
      tick();
    end

    // Edge with i_enable low is ignored.
    enable = 1'b0; n_vsync = 1'b0;
    tick();
    n_vsync = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check("dis_tx", tx, 1);
      check("dis_busy", busy, 0);
      tick();
    end
    enable = 1'b1;

    // vsync held low for 1000 cycles -> exactly one frame; enable drop mid-frame is harmless.
    st = $urandom;
    frame(st, $urandom, -1, 1'b1, 100);
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) check("held_low_single", busy, 0);
      tick();
    end
    n_vsync = 1'b1;
    tick(); tick();

    // Asynchronous reset during DATA of byte 2.
    status = 32'hA1B2_C3D4; n_vsync = 1'b0;
    tick();
    n_vsync = 1'b1;
    for (int i = 0; i < 90; i++) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("no_resend_busy", busy, 0);
      check("no_resend_tx", tx, 1);
      tick();
    end
    frame(32'h0F1E_2D3C, 32'h0, -1, 1'b0, -1);

    // Random frames, including one triggered on the first idle cycle after a frame.
    for (int r = 0; r < 3; r++) begin
      st = $urandom;
      frame(st, $urandom, -1, 1'b0, -1);
      tick();
    end
    st = $urandom;
    frame(st, 32'h0, -1, 1'b0, -1);
    st = $urandom;
    frame(st, 32'h0, -1, 1'b0, -1);  // back-to-back: edge on the first idle cycle

    // 104 clocks per bit, an edge every 16000 cycles.
    for (int f = 0; f < 3; f++) begin
      st = $urandom;
      status_b = st;
      n_vsync_b = 1'b0;
      tick();
      n_vsync_b = 1'b1;
      status_b = $urandom;
      busy_len = 0;
      drop_cnt = 0;
      for (int c = 0; c < 15999; c++) begin
        if (busy_b) busy_len++;
        if (drop_b) drop_cnt++;
        if (c == 0) check("b_busy_start", busy_b, 1);
        if (c == 5200) check("b_busy_end", busy_b, 0);
        if (c < 5200 && c % 104 == 52) check("b_tx_bit", tx_b, expected_bit(st, c / 104));
        tick();
      end
      check("b_frame_len", busy_len, 5200);
      check("b_no_drop", drop_cnt, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
